// File: rtl/pb_defs.sv
// Shared definitions for the pushbutton debouncer: per-channel FSM encodings
// and the counter-width helper used by every channel.
package pb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } pb_state_e;

  // Counters hold values up to n-1, so $clog2(n)+1 bits always has headroom.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// Single pushbutton channel: synchronizer, debounce counter, and the
// press/release/auto-repeat FSM with registered one-cycle pulse outputs.
module pb_debounce_ch
  import pb_defs::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic evt
);

  localparam int DB_W   = cnt_w(DB_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int REP_W  = cnt_w(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_bit;
  logic                   lvl_p1;
  logic [DB_W-1:0]        db_cnt;
  logic                   rise;
  logic                   fall;
  pb_state_e              state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [REP_W-1:0]       rep_cnt;

  assign sync_bit = sync_p0[SYNC_STAGES-1];

  // Stage p0: metastability chain, the only consumer of the raw pb input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pb};
    end
  end

  // Stage p1: accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_p1 <= 1'b0;
      db_cnt <= '0;
    end else if (sync_bit == lvl_p1) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      lvl_p1 <= ~lvl_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // The output level lags lvl_p1 by one register, so edges are visible here
  assign rise = lvl_p1 & ~level;
  assign fall = ~lvl_p1 & level;

  // Stage p2: registered level, edge pulses and hold/repeat FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= 1'b0;
      press    <= 1'b0;
      rel      <= 1'b0;
      rpt      <= 1'b0;
      evt      <= 1'b0;
      state    <= ST_IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      level <= lvl_p1;
      press <= rise;
      rel   <= fall;
      rpt   <= 1'b0;
      evt   <= rise;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state <= ST_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state   <= ST_REPEAT;
            rep_cnt <= '0;
            rpt     <= 1'b1;
            evt     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_REPEAT: begin
          // A release on the same edge suppresses the repeat pulse
          if (fall) begin
            state <= ST_IDLE;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
            rpt     <= 1'b1;
            evt     <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// Multi-channel pushbutton debouncer: WIDTH independent channels, each with
// level, press, release, auto-repeat and combined event outputs.
module pb_debounce
  import pb_defs::*;
#(
  parameter int WIDTH         = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pb,
  output logic [WIDTH-1:0] pb_level,
  output logic [WIDTH-1:0] pb_press,
  output logic [WIDTH-1:0] pb_release,
  output logic [WIDTH-1:0] pb_repeat,
  output logic [WIDTH-1:0] pb_event
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pb_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .pb   (pb[i]),
      .level(pb_level[i]),
      .press(pb_press[i]),
      .rel  (pb_release[i]),
      .rpt  (pb_repeat[i]),
      .evt  (pb_event[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce with short debounce/hold/repeat periods; expected
// pulses are scheduled into a scoreboard queue and checked every cycle.
module tb_pb_debounce;

  localparam int W    = 5;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int LAT  = SYNC + DB;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pb;
  logic [W-1:0] pb_level;
  logic [W-1:0] pb_press;
  logic [W-1:0] pb_release;
  logic [W-1:0] pb_repeat;
  logic [W-1:0] pb_event;

  pb_debounce #(
    .WIDTH        (W),
    .SYNC_STAGES  (SYNC),
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb        (pb),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_repeat (pb_repeat),
    .pb_event  (pb_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] pr;
    logic [W-1:0] rl;
    logic [W-1:0] rp;
  } ev_t;

  typedef struct {
    logic [W-1:0] mask;
    int           len;
    bit           pressed;
    int           nrep;
  } vec_t;

  ev_t          sb[$];
  vec_t         vecs[6];
  int           cyc;
  int           checks;
  int           errors;
  logic [W-1:0] exp_level;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [W-1:0] pr, input logic [W-1:0] rl,
                      input logic [W-1:0] rp);
    sb.push_back('{cyc: c, pr: pr, rl: rl, rp: rp});
  endtask

  // Expected pulses for a button held len cycles starting at edge s
  task automatic schedule(input int s, input logic [W-1:0] m, input int len,
                          input bit pressed, input int nrep);
    if (pressed) begin
      push(s + LAT, m, '0, '0);
      for (int k = 0; k < nrep; k++) push(s + LAT + HOLD + k * REP, '0, '0, m);
      push(s + len + LAT, '0, m, '0);
    end
  endtask

  task automatic tick();
    logic [W-1:0] epr;
    logic [W-1:0] erl;
    logic [W-1:0] erp;
    @(posedge clk);
    #1;
    cyc++;
    epr = '0;
    erl = '0;
    erp = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        epr |= sb[i].pr;
        erl |= sb[i].rl;
        erp |= sb[i].rp;
        sb.delete(i);
      end
    end
    exp_level = (exp_level | epr) & ~erl;
    chk("pb_level", pb_level, exp_level);
    chk("pb_press", pb_press, epr);
    chk("pb_release", pb_release, erl);
    chk("pb_repeat", pb_repeat, erp);
    chk("pb_event", pb_event, epr | erp);
  endtask

  task automatic run_vec(input vec_t v);
    int s;
    s = cyc + 1;
    pb = v.mask;
    schedule(s, v.mask, v.len, v.pressed, v.nrep);
    repeat (v.len) tick();
    pb = '0;
    repeat (LAT + 6) tick();
  endtask

  initial begin
    int s;
    vecs[0] = '{mask: 5'b00001, len: 25, pressed: 1'b1, nrep: 5};
    vecs[1] = '{mask: 5'b00010, len: 3,  pressed: 1'b0, nrep: 0};
    vecs[2] = '{mask: 5'b10001, len: 12, pressed: 1'b1, nrep: 1};
    vecs[3] = '{mask: 5'b00100, len: 4,  pressed: 1'b1, nrep: 0};
    vecs[4] = '{mask: 5'b01000, len: 10, pressed: 1'b1, nrep: 0};
    vecs[5] = '{mask: 5'b11111, len: 14, pressed: 1'b1, nrep: 2};

    cyc       = 0;
    checks    = 0;
    errors    = 0;
    exp_level = '0;
    rst_n     = 1'b0;
    pb        = '0;
    #1;
    chk("reset_level", pb_level, '0);
    chk("reset_press", pb_press, '0);
    chk("reset_event", pb_event, '0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bounce on bit 2: 2-cycle pulses never accepted, then one clean press
    for (int i = 0; i < 10; i++) begin
      pb[2] = ((i / 2) % 2 == 1);
      tick();
    end
    s = cyc + 1;
    pb[2] = 1'b1;
    schedule(s, 5'b00100, 8, 1'b1, 0);
    repeat (8) tick();
    pb = '0;
    repeat (LAT + 6) tick();

    // Asynchronous reset while bit 3 is auto-repeating, button kept held
    s = cyc + 1;
    pb[3] = 1'b1;
    push(s + LAT, 5'b01000, '0, '0);
    push(s + LAT + HOLD, '0, '0, 5'b01000);
    push(s + LAT + HOLD + REP, '0, '0, 5'b01000);
    repeat (LAT + HOLD + REP + 1) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", pb_level, '0);
    chk("async_rst_repeat", pb_repeat, '0);
    chk("async_rst_event", pb_event, '0);
    sb.delete();
    exp_level = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    s = cyc + 1;
    schedule(s, 5'b01000, 12, 1'b1, 1);
    repeat (12) tick();
    pb = '0;
    repeat (LAT + 6) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d want=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
